// File: rtl/grid_stream_reader.sv
// rtl/grid_stream_reader.sv - row-major grid scan engine feeding a valid/ready cell stream
// Drives the block RAM read address and re-times read data through a 2-entry output buffer.
module grid_stream_reader #(
  parameter int WIDTH  = 8,
  parameter int GRID_W = 16,
  parameter int GRID_H = 16,
  parameter int ADDRW  = $clog2(GRID_W * GRID_H),
  parameter int XW     = (GRID_W > 1) ? $clog2(GRID_W) : 1,
  parameter int YW     = (GRID_H > 1) ? $clog2(GRID_H) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [ADDRW-1:0] addr_read,
  input  logic [WIDTH-1:0] data_in,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [XW-1:0]    m_x,
  output logic [YW-1:0]    m_y,
  output logic             m_last
);
  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN} state_t;

  localparam logic [XW-1:0] X_MAX = XW'(GRID_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(GRID_H - 1);

  state_t                 state_q, state_d;
  logic [ADDRW-1:0]       addr_q, addr_d;
  logic [XW-1:0]          x_q, x_d;
  logic [YW-1:0]          y_q, y_d;
  logic                   inflight_q, inflight_d;
  logic [XW-1:0]          tag_x_q, tag_x_d;
  logic [YW-1:0]          tag_y_q, tag_y_d;
  logic                   tag_last_q, tag_last_d;
  logic                   done_q, done_d;
  logic [1:0][WIDTH-1:0]  buf_data_q, buf_data_d;
  logic [1:0][XW-1:0]     buf_x_q, buf_x_d;
  logic [1:0][YW-1:0]     buf_y_q, buf_y_d;
  logic [1:0]             buf_last_q, buf_last_d;
  logic                   rd_ptr_q, rd_ptr_d;
  logic                   wr_ptr_q, wr_ptr_d;
  logic [1:0]             occ_q, occ_d;

  logic pop, push, issue, cell_last;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    x_d        = x_q;
    y_d        = y_q;
    inflight_d = 1'b0;
    tag_x_d    = tag_x_q;
    tag_y_d    = tag_y_q;
    tag_last_d = tag_last_q;
    done_d     = 1'b0;
    buf_data_d = buf_data_q;
    buf_x_d    = buf_x_q;
    buf_y_d    = buf_y_q;
    buf_last_d = buf_last_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    occ_d      = occ_q;

    pop       = m_valid & m_ready;
    push      = inflight_q;
    cell_last = (x_q == X_MAX) && (y_q == Y_MAX);
    // Only issue when the read can be guaranteed a buffer slot on arrival.
    issue     = (state_q == S_SCAN) &&
                (({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SCAN;
          addr_d  = '0;
          x_d     = '0;
          y_d     = '0;
        end
      end
      S_SCAN: begin
        if (issue && cell_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if ((occ_q == 2'd0) && !inflight_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (issue) begin
      addr_d     = addr_q + ADDRW'(1);
      inflight_d = 1'b1;
      tag_x_d    = x_q;
      tag_y_d    = y_q;
      tag_last_d = cell_last;
      if (x_q == X_MAX) begin
        x_d = '0;
        y_d = y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end

    if (push) begin
      buf_data_d[wr_ptr_q] = data_in;
      buf_x_d[wr_ptr_q]    = tag_x_q;
      buf_y_d[wr_ptr_q]    = tag_y_q;
      buf_last_d[wr_ptr_q] = tag_last_q;
      wr_ptr_d             = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;

    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      inflight_q <= 1'b0;
      tag_x_q    <= '0;
      tag_y_q    <= '0;
      tag_last_q <= 1'b0;
      done_q     <= 1'b0;
      buf_data_q <= '0;
      buf_x_q    <= '0;
      buf_y_q    <= '0;
      buf_last_q <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      x_q        <= x_d;
      y_q        <= y_d;
      inflight_q <= inflight_d;
      tag_x_q    <= tag_x_d;
      tag_y_q    <= tag_y_d;
      tag_last_q <= tag_last_d;
      done_q     <= done_d;
      buf_data_q <= buf_data_d;
      buf_x_q    <= buf_x_d;
      buf_y_q    <= buf_y_d;
      buf_last_q <= buf_last_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      occ_q      <= occ_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign addr_read = addr_q;
  assign m_valid   = (occ_q != 2'd0);
  assign m_data    = buf_data_q[rd_ptr_q];
  assign m_x       = buf_x_q[rd_ptr_q];
  assign m_y       = buf_y_q[rd_ptr_q];
  assign m_last    = m_valid & buf_last_q[rd_ptr_q];
endmodule

// File: tb/tb_grid_stream_reader.sv
// tb/tb_grid_stream_reader.sv - scoreboard bench for grid_stream_reader
// Instance a is a 4x3 grid, instance b a 16x16 grid with random backpressure.
module tb_grid_stream_reader;
  localparam int AN = 12;
  localparam int BN = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       a_start = 1'b0, a_ready = 1'b1;
  logic       a_busy, a_done, a_valid, a_last;
  logic [3:0] a_addr;
  logic [7:0] a_din = '0, a_data;
  logic [1:0] a_x, a_y;

  logic       b_start = 1'b0, b_ready = 1'b0;
  logic       b_busy, b_done, b_valid, b_last;
  logic [7:0] b_addr;
  logic [7:0] b_din = '0, b_data;
  logic [3:0] b_x, b_y;

  grid_stream_reader #(.WIDTH(8), .GRID_W(4), .GRID_H(3)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done),
    .addr_read(a_addr), .data_in(a_din), .m_valid(a_valid), .m_ready(a_ready),
    .m_data(a_data), .m_x(a_x), .m_y(a_y), .m_last(a_last));

  grid_stream_reader #(.WIDTH(8), .GRID_W(16), .GRID_H(16)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
    .addr_read(b_addr), .data_in(b_din), .m_valid(b_valid), .m_ready(b_ready),
    .m_data(b_data), .m_x(b_x), .m_y(b_y), .m_last(b_last));

  logic [7:0] mem_a [16];
  logic [7:0] mem_b [256];
  always @(posedge clk) begin
    a_din <= mem_a[a_addr];
    b_din <= mem_b[b_addr];
  end

  int n_cmp = 0, n_bad = 0, cyc = 0;
  int a_beats = 0, b_beats = 0, a_dones = 0, b_dones = 0;
  time b_acc_t = 0;
  logic [12:0] qa [$];
  logic [16:0] qb [$];
  logic [12:0] ea;
  logic [16:0] eb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a();
    for (int i = 0; i < AN; i++)
      qa.push_back({mem_a[i], 2'(i % 4), 2'(i / 4), (i == AN - 1)});
  endtask

  // Monitor: pops the scoreboard on every accepted beat.
  always @(negedge clk) begin
    if (!rst) begin
      if (a_valid && a_ready) begin
        a_beats++;
        if (qa.size() == 0) check("a_extra_beat", 32'(a_beats), 32'(0));
        else begin
          ea = qa.pop_front();
          check("a_beat", 32'({a_data, a_x, a_y, a_last}), 32'(ea));
        end
      end
      if (b_valid && b_ready) begin
        b_beats++;
        b_acc_t = $time;
        if (qb.size() == 0) check("b_extra_beat", 32'(b_beats), 32'(0));
        else begin
          eb = qb.pop_front();
          check("b_beat", 32'({b_data, b_x, b_y, b_last}), 32'(eb));
        end
      end
      if (a_done) a_dones++;
      if (b_done) b_dones++;
    end
  end

  int  d0;
  bit  seen;
  time done_t;

  initial begin
    for (int i = 0; i < 16; i++) mem_a[i] = 8'(i + 16);
    for (int i = 0; i < BN; i++) mem_b[i] = 8'($urandom_range(0, 255));

    tick(); tick();
    check("reset_a", 32'({a_busy, a_done, a_valid, a_last, a_addr, a_data, a_x, a_y}), 32'(0));
    rst = 1'b0;
    tick();

    // Full-rate scan of 4x3.
    a_start = 1'b1; push_a(); cyc = 0;
    for (int c = 1; c <= 17; c++) begin
      tick(); a_start = 1'b0; cyc = c;
      if (c == 1) check("t1_addr_c1", 32'(a_addr), 32'(0));
      if (c == 2) check("t1_addr_c2", 32'(a_addr), 32'(1));
      check("t1_busy", 32'(a_busy), 32'(c >= 1 && c <= 15));
      check("t1_done", 32'(a_done), 32'(c == 16));
      check("t1_valid", 32'(a_valid), 32'(c >= 3 && c <= 14));
    end
    check("t1_beats", 32'(a_beats), 32'(AN));
    check("t1_q_empty", 32'(qa.size()), 32'(0));

    // Stall from cycle 3 to cycle 9.
    a_beats = 0; d0 = a_dones; a_start = 1'b1; push_a(); cyc = 0;
    for (int c = 1; c <= 40; c++) begin
      tick(); a_start = 1'b0; cyc = c;
      if (c == 3) a_ready = 1'b0;
      if (c == 10) a_ready = 1'b1;
      if (c >= 3 && c <= 9)
        check("t2_stall_hold", 32'({a_valid, a_data, a_addr}), 32'({1'b1, 8'h10, 4'd2}));
    end
    check("t2_beats", 32'(a_beats), 32'(AN));
    check("t2_q_empty", 32'(qa.size()), 32'(0));
    check("t2_dones", 32'(a_dones - d0), 32'(1));

    // start ignored in SCAN/DRAIN, accepted in the done cycle.
    a_beats = 0; d0 = a_dones; a_start = 1'b1; push_a(); cyc = 0;
    for (int c = 1; c <= 40; c++) begin
      tick(); a_start = 1'b0; cyc = c;
      if (c == 2 || c == 14) a_start = 1'b1;
      if (c == 14) check("t4_drain_busy", 32'(a_busy), 32'(1));
      if (c == 16) begin
        check("t4_done_c16", 32'(a_done), 32'(1));
        a_start = 1'b1; push_a();
      end
      if (c == 17) check("t4_busy_c17", 32'(a_busy), 32'(1));
    end
    check("t4_beats", 32'(a_beats), 32'(2 * AN));
    check("t4_q_empty", 32'(qa.size()), 32'(0));
    check("t4_dones", 32'(a_dones - d0), 32'(2));

    // Reset in cycle 6 of a scan.
    d0 = a_dones; a_start = 1'b1; push_a(); cyc = 0;
    for (int c = 1; c <= 5; c++) begin
      tick(); a_start = 1'b0; cyc = c;
    end
    tick(); cyc = 6;
    rst = 1'b1; #1;
    check("t5_rst_outs", 32'({a_busy, a_done, a_valid, a_last, a_addr, a_data, a_x, a_y}), 32'(0));
    tick(); tick();
    rst = 1'b0; qa.delete();
    for (int c = 0; c < 6; c++) tick();
    check("t5_no_done", 32'(a_dones - d0), 32'(0));
    check("t5_idle", 32'({a_busy, a_valid}), 32'(0));
    a_beats = 0; a_start = 1'b1; push_a(); cyc = 0;
    for (int c = 1; c <= 20; c++) begin
      tick(); a_start = 1'b0; cyc = c;
    end
    check("t5_beats", 32'(a_beats), 32'(AN));
    check("t5_q_empty", 32'(qa.size()), 32'(0));
    check("t5_dones", 32'(a_dones - d0), 32'(1));

    // 16x16 with random backpressure.
    for (int i = 0; i < BN; i++) qb.push_back({mem_b[i], 4'(i % 16), 4'(i / 16), (i == BN - 1)});
    b_start = 1'b1; seen = 1'b0; done_t = 0; cyc = 0;
    for (int c = 1; c <= 3000 && !seen; c++) begin
      tick(); b_start = 1'b0; cyc = c;
      b_ready = 1'($urandom_range(0, 1));
      if (b_done) begin
        seen = 1'b1;
        done_t = $time;
      end
    end
    check("t3_done_seen", 32'(seen), 32'(1));
    check("t3_beats", 32'(b_beats), 32'(BN));
    check("t3_q_empty", 32'(qb.size()), 32'(0));
    check("t3_done_after_last", 32'(done_t > b_acc_t), 32'(1));
    for (int c = 0; c < 5; c++) tick();
    check("t3_dones", 32'(b_dones), 32'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/grid_stream_reader.md
# grid_stream_reader

Single-clock scan engine that sweeps a row-major `GRID_W` x `GRID_H` field stored in a simple dual-port block RAM and emits every cell as a valid/ready stream tagged with its (x, y) coordinate. It sits directly downstream of the block RAM read port: it drives the read address and consumes the read data one cycle later. A 2-entry output buffer absorbs the RAM read latency, so downstream backpressure never loses or duplicates a cell.

## Interface
- `WIDTH`, 8: cell data width; must match the RAM `WIDTH`.
- `GRID_W`, 16: cells per row, ≥ 2.
- `GRID_H`, 16: rows, ≥ 1.
- `ADDRW`, `$clog2(GRID_W*GRID_H)`: RAM address width.
- `XW` / `YW`, `$clog2(GRID_W)` / `$clog2(GRID_H)` (min 1): coordinate widths.

Ports:
- `clk`  in  1  single clock for all logic; also drives the RAM read clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a full scan; sampled only in IDLE.
- `busy`  out  1  high while a scan is in progress.
- `done`  out  1  one-cycle pulse after the final beat has been accepted.
- `addr_read`  out  ADDRW  registered address to the RAM read port.
- `data_in`  in  WIDTH  RAM read data, valid one cycle after `addr_read`.
- `m_valid`  out  1  output beat valid.
- `m_ready`  in  1  downstream accept.
- `m_data`  out  WIDTH  cell value.
- `m_x`, `m_y`  out  XW, YW  cell coordinate.
- `m_last`  out  1  marks cell (GRID_W-1, GRID_H-1).

## Operation
- FSM states:
  - IDLE: `start` → SCAN.
  - SCAN: after issuing the last address → DRAIN.
  - DRAIN: when the buffer is empty and no read is in flight → IDLE, with `done`=1 in the first IDLE cycle.
- `start` is ignored in SCAN and DRAIN. `start` is accepted in the IDLE cycle in which `done` is high.
- Issue rule: in SCAN, a read is issued in cycle t when `occ + inflight - pop < 2`.
  - `occ` is buffer occupancy (0..2).
  - `inflight` is 1 if a read was issued in t-1.
  - `pop` = `m_valid & m_ready`.
- On issue:
  - `addr_read` (the address being read this cycle) advances at the edge.
  - The x/y counters advance; x wraps GRID_W-1→0 and increments y.
  - The linear address increments by 1. No multiplier.
- When not issuing, `addr_read` holds its value. The RAM reads it harmlessly, and the data is discarded.
- In-flight tag: {x, y, last} is registered alongside the issue. At the next edge, `data_in` and the tag are written into the buffer tail.
- Output: the buffer head drives `m_valid`/`m_data`/`m_x`/`m_y`/`m_last`.
  - Head fields are stable while `m_valid & !m_ready`.
  - A simultaneous push and pop in the same cycle is legal and keeps `occ` unchanged.
- Cells are emitted in order (0,0),(1,0)…(GRID_W-1,GRID_H-1); exactly GRID_W*GRID_H beats per scan.
- `busy` = state ≠ IDLE.

## Timing
- Reset values: `busy`=0, `done`=0, `m_valid`=0, `m_last`=0, `addr_read`=0, `m_data`/`m_x`/`m_y`=0, `occ`=0, `inflight`=0, state IDLE.
- Reset mid-scan: the scan is abandoned immediately. No `done` pulse. The buffer is emptied; the next `start` scans from (0,0).
- Latency: `start` high in cycle 0 gives:
  - SCAN and `addr_read`=0 in cycle 1;
  - `data_in`=mem[0] in cycle 2;
  - `m_valid` with mem[0] in cycle 3.
- With `m_ready` held high, throughput is 1 beat/cycle with no bubbles after the first beat.
- Scan of N cells with `m_ready` held high:
  - beats in cycles 3..N+2;
  - `busy` high in cycles 1..N+3;
  - `done` high in cycle N+4.
- The `done` pulse is registered and lasts exactly 1 cycle.

## Test plan
- 4x3 grid, mem[i]=i+0x10, `m_ready`=1, `start` in cycle 0 → 12 beats in cycles 3..14 with data 0x10..0x1B; x/y sweep row-major; `m_last` only on (3,2); `busy` high 1..15; `done` high in cycle 16 only.
- Same grid, `m_ready`=0 from cycle 3 to cycle 9, then 1 → issues only in cycles 1,2; `addr_read` holds 2; `m_data`=0x10 stable in cycles 3..9; all 12 beats are then delivered in order, with no duplicates or drops.
- Random `m_ready` (50%), 16x16 grid → 256 beats exactly; beat k carries mem[k] and (k%16, k/16); `done` is asserted once after the last accepted beat.
- `start` pulsed during SCAN and DRAIN → ignored, and a single scan completes; `start` in the `done` cycle → second scan begins, with `busy` high the next cycle.
- `rst` asserted in cycle 6 of a 4x3 scan → all outputs 0 immediately and no `done`; a fresh `start` then yields the full 12-beat sequence from (0,0).
